// File: rtl/sha256_host_ctrl.sv
// Host-side controller for the simplified SHA-256 engine: streams the message into
// the shared word memory, runs the start/done handshake and reads back h0..h7.
module sha256_host_ctrl #(
    parameter int          NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_ADDR     = 16'h0000,
    parameter logic [15:0] OUT_ADDR     = 16'h0100,
    parameter int          TIMEOUT      = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic [255:0] expected_hash,
    output logic         sha_start,
    input  logic         sha_done,
    output logic         mem_sel,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic         busy,
    output logic         hash_valid,
    output logic [255:0] hash,
    output logic         match,
    output logic         err
);

    localparam int CNT_W = $clog2(NUM_OF_WORDS + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_KICK      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_RD        = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic [3:0]       rd_cnt;
    logic             match_q;
    logic             hash_eq;

    assign in_ready   = (state == S_LOAD) && (cnt < CNT_W'(NUM_OF_WORDS));
    assign mem_sel    = (state == S_LOAD) || (state == S_RD);
    assign sha_start  = (state == S_KICK) || (state == S_WAIT_BUSY);
    assign busy       = (state != S_IDLE);
    assign hash_valid = (state == S_FINISH);
    assign hash_eq    = (hash == expected_hash);

    // The live compare is shown during the FINISH pulse; the registered copy holds it afterwards.
    assign match = (state == S_FINISH) ? (hash_eq && !err) : match_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            timer          <= '0;
            rd_cnt         <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            hash           <= '0;
            err            <= 1'b0;
            match_q        <= 1'b0;
        end else begin
            // NOTE: default first so every state that does not write leaves mem_we low.
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        cnt     <= '0;
                        err     <= 1'b0;
                        match_q <= 1'b0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        mem_we         <= 1'b1;
                        mem_addr       <= MSG_ADDR + 16'(cnt);
                        mem_write_data <= in_data;
                        cnt            <= cnt + 1'b1;
                    end else if (cnt == CNT_W'(NUM_OF_WORDS)) begin
                        // This cycle carries the last word's write.
                        state <= S_KICK;
                    end
                end
                S_KICK: begin
                    timer <= '0;
                    state <= sha_done ? S_WAIT_BUSY : S_WAIT_DONE;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    timer <= timer + 1'b1;
                    if (timer == TMR_W'(TIMEOUT - 2)) begin
                        err   <= 1'b1;
                        state <= S_FINISH;
                    end else if (state == S_WAIT_BUSY && !sha_done) begin
                        state <= S_WAIT_DONE;
                    end else if (state == S_WAIT_DONE && sha_done) begin
                        rd_cnt   <= '0;
                        mem_addr <= OUT_ADDR;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    // Sync read: word k arrives one cycle after its address, h0 ends up on top.
                    rd_cnt   <= rd_cnt + 1'b1;
                    mem_addr <= OUT_ADDR + 16'(rd_cnt) + 16'd1;
                    if (rd_cnt != 4'd0) begin
                        hash <= {hash[223:0], mem_read_data};
                    end
                    if (rd_cnt == 4'd8) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    match_q <= hash_eq && !err;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: memory + engine model, write and result scoreboards,
// and a second instance with a short timeout for the stuck-engine case.
module tb_sha256_host_ctrl;

    localparam logic [15:0] OUT_ADDR = 16'h0100;
    localparam int          N_WORDS  = 20;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [255:0] hash;
        logic         match;
        logic         err;
    } res_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         go, go_to, in_valid;
    logic [31:0]  in_data;
    logic [255:0] expected_hash;

    logic         in_ready, sha_start, mem_sel, mem_we, busy, hash_valid, match, err;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic [255:0] hash;
    logic         sha_done = 1'b1;

    logic         in_ready_to, sha_start_to, mem_sel_to, mem_we_to, busy_to, hash_valid_to, match_to, err_to;
    logic [15:0]  mem_addr_to;
    logic [31:0]  mem_write_data_to;
    logic [255:0] hash_to;
    logic         sha_done_to = 1'b1;
    logic [31:0]  mem_read_data_to = 32'hA5A5A5A5;

    sha256_host_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .go(go), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .expected_hash(expected_hash), .sha_start(sha_start),
        .sha_done(sha_done), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy),
        .hash_valid(hash_valid), .hash(hash), .match(match), .err(err)
    );

    sha256_host_ctrl #(.TIMEOUT(64)) u_to (
        .clk(clk), .reset_n(reset_n), .go(go_to), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_to), .expected_hash(expected_hash), .sha_start(sha_start_to),
        .sha_done(sha_done_to), .mem_sel(mem_sel_to), .mem_we(mem_we_to), .mem_addr(mem_addr_to),
        .mem_write_data(mem_write_data_to), .mem_read_data(mem_read_data_to), .busy(busy_to),
        .hash_valid(hash_valid_to), .hash(hash_to), .match(match_to), .err(err_to)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;
    int   n_hv     = 0;
    int   n_hv_to  = 0;
    int   cyc      = 0;
    wr_t  wr_q[$];
    res_t res_q[$];
    res_t res_to_q[$];

    // Memory and engine model
    logic [31:0] mem [0:65535];
    logic [31:0] eng_words [8];
    int          eng_len = 100;
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;
    logic        clr_msg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr_msg) begin
            for (int i = 0; i < N_WORDS; i++) mem[i] <= 32'hDEADBEEF;
        end
        if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
        if (!eng_busy) begin
            if (sha_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 0;
                sha_done <= 1'b0;
            end
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == eng_len - 1) begin
                for (int k = 0; k < 8; k++) mem[OUT_ADDR + 16'(k)] <= eng_words[k];
                sha_done <= 1'b1;
                eng_busy <= 1'b0;
            end
        end
    end

    // Write scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            n_writes++;
            n_checks++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: addr=%h data=%h, required no write", mem_addr, mem_write_data);
            end else begin
                e = wr_q.pop_front();
                if (mem_addr !== e.addr || mem_write_data !== e.data || mem_sel !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_beat: addr=%h data=%h sel=%b, required addr=%h data=%h sel=1",
                             mem_addr, mem_write_data, mem_sel, e.addr, e.data);
                end
            end
        end
    end

    // Result scoreboards
    always @(negedge clk) begin
        res_t r;
        if (hash_valid === 1'b1) begin
            n_hv++;
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: hash_valid with no job expected");
            end else begin
                r = res_q.pop_front();
                if (hash !== r.hash || match !== r.match || err !== r.err) begin
                    n_fail++;
                    $display("FAIL result: hash=%h match=%b err=%b, required hash=%h match=%b err=%b",
                             hash, match, err, r.hash, r.match, r.err);
                end
            end
        end
        if (hash_valid_to === 1'b1) begin
            n_hv_to++;
            n_checks++;
            if (res_to_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_to_unexpected: hash_valid with no job expected");
            end else begin
                r = res_to_q.pop_front();
                if (hash_to !== r.hash || match_to !== r.match || err_to !== r.err) begin
                    n_fail++;
                    $display("FAIL result_to: hash=%h match=%b err=%b, required hash=%h match=%b err=%b",
                             hash_to, match_to, err_to, r.hash, r.match, r.err);
                end
            end
        end
    end

    function automatic logic [255:0] pack_words();
        logic [255:0] p = '0;
        for (int k = 0; k < 8; k++) p = {p[223:0], eng_words[k]};
        return p;
    endfunction

    function automatic int msg_errors(input logic [31:0] base);
        int e = 0;
        for (int i = 0; i < N_WORDS; i++) if (mem[i] !== base + 32'(i)) e++;
        return e;
    endfunction

    task automatic clear_msg();
        @(negedge clk); clr_msg = 1'b1;
        @(negedge clk); clr_msg = 1'b0;
    endtask

    task automatic do_go(input bit to);
        @(negedge clk);
        if (to) go_to = 1'b1; else go = 1'b1;
        @(negedge clk);
        go = 1'b0; go_to = 1'b0;
    endtask

    // Offers n beats (every cycle, or every other cycle when gap=1); returns at the
    // negedge following the last accepted beat.
    task automatic load(input bit to, input int n, input bit gap, input logic [31:0] base);
        int  i = 0;
        int  c = 0;
        logic rdy;
        wr_t e;
        while (i < n && c < 200) begin
            rdy = to ? in_ready_to : in_ready;
            if (rdy && (!gap || (c % 2 == 0))) begin
                in_valid = 1'b1;
                in_data  = base + 32'(i);
                if (!to) begin
                    e.addr = 16'(i);
                    e.data = base + 32'(i);
                    wr_q.push_back(e);
                end
                i++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (i != n) begin
            n_fail++;
            $display("FAIL load_accept: %0d beats accepted, required %0d", i, n);
        end
    endtask

    task automatic wait_hv(input bit to, input int bound);
        int c = 0;
        while (((to ? hash_valid_to : hash_valid) !== 1'b1) && c < bound) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if ((to ? hash_valid_to : hash_valid) !== 1'b1) begin
            n_fail++;
            $display("FAIL hash_valid_wait: hash_valid=0 after %0d cycles, required 1", bound);
        end else begin
            @(negedge clk);
            n_checks++;
            if ((to ? hash_valid_to : hash_valid) !== 1'b0) begin
                n_fail++;
                $display("FAIL hash_valid_width: hash_valid=1 on second cycle, required 0");
            end
        end
    endtask

    task automatic push_result(input logic [255:0] exp_in);
        res_t r;
        expected_hash = exp_in;
        r.hash  = pack_words();
        r.match = (exp_in == pack_words());
        r.err   = 1'b0;
        res_q.push_back(r);
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({in_ready, sha_start, mem_sel, mem_we, busy, hash_valid, match, err} !== 8'h00 ||
            mem_addr !== 16'h0 || mem_write_data !== 32'h0 || hash !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h hash=%h, required all 0",
                     {in_ready, sha_start, mem_sel, mem_we, busy, hash_valid, match, err},
                     mem_addr, mem_write_data, hash);
        end
        n_checks++;
        if ({in_ready_to, sha_start_to, mem_sel_to, mem_we_to, busy_to, hash_valid_to, match_to, err_to} !== 8'h00 ||
            hash_to !== 256'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_to: ctl=%b hash=%h, required all 0",
                     {in_ready_to, sha_start_to, mem_sel_to, mem_we_to, busy_to, hash_valid_to, match_to, err_to}, hash_to);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_load_streaming();
        int w0;
        logic [255:0] exp_h;
        for (int k = 0; k < 8; k++) eng_words[k] = 32'hC0DE0000 + 32'(k);
        exp_h = pack_words();
        clear_msg();
        push_result(exp_h);
        w0 = n_writes;
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b0, 32'h1);
        n_checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b1 || sha_start !== 1'b0) begin
            n_fail++;
            $display("FAIL last_write_cycle: in_ready=%b mem_we=%b sha_start=%b, required 0 1 0", in_ready, mem_we, sha_start);
        end
        @(negedge clk);
        n_checks++;
        if (sha_start !== 1'b1 || mem_sel !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL kick: sha_start=%b mem_sel=%b mem_we=%b, required 1 0 0", sha_start, mem_sel, mem_we);
        end
        wait_hv(1'b0, 400);
        n_checks++;
        if (n_writes - w0 != N_WORDS || msg_errors(32'h1) != 0) begin
            n_fail++;
            $display("FAIL stream_mem: writes=%0d bad_words=%0d, required 20 and 0", n_writes - w0, msg_errors(32'h1));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (hash !== exp_h || match !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL result_hold: hash=%h match=%b err=%b busy=%b, required hash=%h 1 0 0", hash, match, err, busy, exp_h);
        end
    endtask

    task automatic test_load_gapped();
        int w0;
        clear_msg();
        push_result(pack_words());
        w0 = n_writes;
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b1, 32'h1);
        wait_hv(1'b0, 400);
        n_checks++;
        if (n_writes - w0 != N_WORDS || msg_errors(32'h1) != 0) begin
            n_fail++;
            $display("FAIL gapped_mem: writes=%0d bad_words=%0d, required 20 and 0", n_writes - w0, msg_errors(32'h1));
        end
    endtask

    task automatic test_hash_compare();
        int h0;
        logic [255:0] exp_h;
        for (int k = 0; k < 8; k++) eng_words[k] = 32'h11111111 * 32'(k + 1);
        exp_h = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        h0 = n_hv;
        push_result(exp_h);
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b0, 32'h1);
        wait_hv(1'b0, 400);
        push_result(exp_h ^ (256'h1 << 77));
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b0, 32'h1);
        wait_hv(1'b0, 400);
        repeat (2) @(negedge clk);
        n_checks++;
        if (n_hv - h0 != 2 || match !== 1'b0 || hash !== exp_h) begin
            n_fail++;
            $display("FAIL compare_jobs: pulses=%0d match=%b hash=%h, required 2 0 %h", n_hv - h0, match, hash, exp_h);
        end
    endtask

    task automatic test_timeout();
        int   kick;
        int   c = 0;
        int   sel_hits = 0;
        res_t r;
        expected_hash = '0;
        r.hash = '0; r.match = 1'b0; r.err = 1'b1;
        res_to_q.push_back(r);
        do_go(1'b1);
        load(1'b1, N_WORDS, 1'b0, 32'h40);
        while (sha_start_to !== 1'b1 && c < 10) begin @(negedge clk); c++; end
        kick = cyc;
        c = 0;
        while (hash_valid_to !== 1'b1 && c < 200) begin
            if (mem_sel_to !== 1'b0) sel_hits++;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (cyc - kick != 64 || hash_valid_to !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_latency: hash_valid=%b %0d cycles after kick, required 1 at 64", hash_valid_to, cyc - kick);
        end
        n_checks++;
        if (sel_hits != 0 || sha_start_to !== 1'b0 || err_to !== 1'b1 || match_to !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: mem_sel_cycles=%0d sha_start=%b err=%b match=%b, required 0 0 1 0",
                     sel_hits, sha_start_to, err_to, match_to);
        end
        @(negedge clk);
        n_checks++;
        if (err_to !== 1'b1 || match_to !== 1'b0 || busy_to !== 1'b0 || hash_valid_to !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hold: err=%b match=%b busy=%b hv=%b, required 1 0 0 0", err_to, match_to, busy_to, hash_valid_to);
        end
    endtask

    task automatic test_reset_mid_job();
        int w0;
        w0 = n_writes;
        do_go(1'b0);
        load(1'b0, 7, 1'b0, 32'h500);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, sha_start, mem_sel, mem_we, busy, hash_valid, match, err} !== 8'h00 ||
            mem_addr !== 16'h0 || mem_write_data !== 32'h0 || hash !== 256'h0) begin
            n_fail++;
            $display("FAIL async_reset: ctl=%b addr=%h wdata=%h hash=%h, required all 0",
                     {in_ready, sha_start, mem_sel, mem_we, busy, hash_valid, match, err}, mem_addr, mem_write_data, hash);
        end
        repeat (3) @(negedge clk);
        wr_q.delete();
        reset_n = 1'b1;
        n_checks++;
        if (n_writes - w0 != 7) begin
            n_fail++;
            $display("FAIL abort_writes: %0d writes, required 7", n_writes - w0);
        end
        clear_msg();
        push_result(pack_words());
        w0 = n_writes;
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b0, 32'h900);
        wait_hv(1'b0, 400);
        n_checks++;
        if (n_writes - w0 != N_WORDS || msg_errors(32'h900) != 0) begin
            n_fail++;
            $display("FAIL rerun_mem: writes=%0d bad_words=%0d, required 20 and 0", n_writes - w0, msg_errors(32'h900));
        end
    endtask

    task automatic test_go_while_busy();
        int h0;
        int c = 0;
        int busy_hits = 0;
        h0 = n_hv;
        push_result(pack_words());
        do_go(1'b0);
        load(1'b0, N_WORDS, 1'b0, 32'h1);
        while (sha_done !== 1'b0 && c < 20) begin @(negedge clk); c++; end
        repeat (5) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || mem_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL go_ignored: busy=%b in_ready=%b mem_sel=%b, required 1 0 0", busy, in_ready, mem_sel);
        end
        wait_hv(1'b0, 400);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop: busy=%b after FINISH, required 0", busy);
        end
        repeat (150) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_hits++;
        end
        n_checks++;
        if (n_hv - h0 != 1 || busy_hits != 0) begin
            n_fail++;
            $display("FAIL no_queueing: pulses=%0d busy_cycles=%0d, required 1 and 0", n_hv - h0, busy_hits);
        end
    endtask

    initial begin
        go = 1'b0;
        go_to = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        expected_hash = '0;
        for (int k = 0; k < 8; k++) eng_words[k] = '0;
        test_reset();
        test_load_streaming();
        test_load_gapped();
        test_hash_compare();
        test_timeout();
        test_reset_mid_job();
        test_go_while_busy();
        n_checks++;
        if (wr_q.size() != 0 || res_q.size() != 0 || res_to_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: writes=%0d results=%0d results_to=%0d left, required 0",
                     wr_q.size(), res_q.size(), res_to_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
